// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared instruction/word types for the CPU front end.
// Revision 1.0
`default_nettype none

package mips_cpu_pkg;

  typedef logic [31:0] word_t;
  typedef word_t       inst_t;

  localparam inst_t NOP_INST = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/inst_fifo.sv
// inst_fifo: word FIFO with fill count and synchronous flush.
// Revision 1.0
`default_nettype none

module inst_fifo
  import mips_cpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst,
  input  logic                     flush,
  input  logic                     push,
  input  word_t                    push_word,
  input  logic                     pop,
  output word_t                    head,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_FILL = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  word_t         mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Guards keep fill within 0..DEPTH even if a caller misbehaves.
  always_comb begin
    do_push = push && !flush && (fill != FULL_FILL);
    do_pop  = pop  && !flush && (fill != '0);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (do_push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_feeder.sv
// inst_feeder: assembles little-endian bytes into instructions and feeds the CPU.
// Revision 1.0
`default_nettype none

module inst_feeder
  import mips_cpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst,
  input  logic                     flush,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  input  logic                     cpu_ready,
  output logic                     en,
  output inst_t                    outer_inst,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [15:0]              issued
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam logic [FW-1:0] FULL_FILL = FW'(DEPTH);

  logic [1:0]  byte_idx;
  logic [23:0] lanes;
  logic        xfer;
  logic        push;
  logic        pop;
  word_t       push_word;
  word_t       head;

  // Only the completing byte needs FIFO space; earlier lanes are held locally.
  always_comb begin
    byte_ready = !flush && !((byte_idx == 2'd3) && (fill == FULL_FILL));
    xfer       = byte_valid && byte_ready;
    push       = xfer && (byte_idx == 2'd3);
    push_word  = {byte_data, lanes};
    en         = (fill != '0) && !flush;
    pop        = en && cpu_ready;
    outer_inst = en ? head : NOP_INST;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      byte_idx <= 2'd0;
      lanes    <= '0;
      issued   <= '0;
    end else if (flush) begin
      byte_idx <= 2'd0;
      lanes    <= '0;
    end else begin
      if (xfer) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    lanes[7:0]   <= byte_data;
          2'd1:    lanes[15:8]  <= byte_data;
          2'd2:    lanes[23:16] <= byte_data;
          default: lanes        <= lanes;
        endcase
      end
      if (pop) begin
        issued <= issued + 16'd1;
      end
    end
  end

  inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .flush       (flush),
    .push        (push),
    .push_word   (push_word),
    .pop         (pop),
    .head        (head),
    .fill        (fill)
  );

endmodule

`default_nettype wire

// File: tb/tb_inst_feeder.sv
// tb_inst_feeder: directed table-driven and sequence checks for inst_feeder.
// Revision 1.0
`default_nettype none

module tb_inst_feeder;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        flush = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        cpu_ready = 1'b0;
  logic        en;
  logic [31:0] outer_inst;
  logic [3:0]  fill;
  logic [15:0] issued;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        f;
    logic        exp_rdy;
    logic        exp_en;
    logic [31:0] exp_inst;
    logic [3:0]  exp_fill;
    logic [15:0] exp_iss;
  } vec_t;

  vec_t tbl [19];
  logic [31:0] sb_q [$];

  inst_feeder #(.DEPTH(8)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .flush       (flush),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .cpu_ready   (cpu_ready),
    .en          (en),
    .outer_inst  (outer_inst),
    .fill        (fill),
    .issued      (issued)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b1; flush = 1'b0; byte_valid = 1'b0; cpu_ready = 1'b0;
    @(posedge cpu_clk_50M);
    #1 cpu_rst = 1'b0;
  endtask

  // Offers one byte, waiting a bounded number of cycles for acceptance.
  task automatic send_byte(input logic [7:0] d, input logic rdy);
    bit ok = 1'b0;
    @(negedge cpu_clk_50M);
    byte_valid = 1'b1; byte_data = d; cpu_ready = rdy;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (byte_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge cpu_clk_50M);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL byte_accept_timeout: actual byte_ready=0 required 1 within 50 cycles");
    end
    @(posedge cpu_clk_50M);
    #1 byte_valid = 1'b0; cpu_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rdy);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb_q.size() > 0; n++) begin
      @(negedge cpu_clk_50M);
      cpu_ready = 1'b1;
      #1;
      if (en) chk("drain_order", outer_inst, sb_q.pop_front());
      @(posedge cpu_clk_50M);
      #1 cpu_ready = 1'b0;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: actual %0d words left required 0", sb_q.size());
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd0};
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd0};
    tbl[2]  = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd0};
    tbl[3]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2008000C,  4'd1, 16'd0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2008000C,  4'd1, 16'd0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[7]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[8]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[9]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[10] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211,  4'd1, 16'd1};
    tbl[12] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         4'd1, 16'd1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[14] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[15] = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[16] = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[17] = '{1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 16'd1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDDCCBBAA,  4'd1, 16'd1};

    // Basic assembly, pop, flush and lane order from the vector table.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      @(negedge cpu_clk_50M);
      byte_valid = tbl[i].v; byte_data = tbl[i].d; cpu_ready = tbl[i].r; flush = tbl[i].f;
      #1;
      chk($sformatf("tbl%0d_ready", i),  {31'd0, byte_ready}, {31'd0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d_en", i),     {31'd0, en},         {31'd0, tbl[i].exp_en});
      chk($sformatf("tbl%0d_inst", i),   outer_inst,          tbl[i].exp_inst);
      chk($sformatf("tbl%0d_fill", i),   {28'd0, fill},       {28'd0, tbl[i].exp_fill});
      chk($sformatf("tbl%0d_issued", i), {16'd0, issued},     {16'd0, tbl[i].exp_iss});
    end
    @(negedge cpu_clk_50M);
    byte_valid = 1'b0; cpu_ready = 1'b0; flush = 1'b0;

    // Full FIFO back-pressure on the completing byte, released by one pop.
    do_reset();
    for (int k = 0; k < 8; k++) send_word(32'hA000_0000 + 32'(k), 1'b0);
    @(negedge cpu_clk_50M); #1;
    chk("full_fill", {28'd0, fill}, 32'd8);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    @(negedge cpu_clk_50M);
    byte_valid = 1'b1; byte_data = 8'h5A; cpu_ready = 1'b0;
    #1;
    chk("full_ready_low", {31'd0, byte_ready}, 32'd0);
    chk("full_fill_hold", {28'd0, fill}, 32'd8);
    @(negedge cpu_clk_50M);
    cpu_ready = 1'b1;
    #1;
    chk("no_bypass_ready", {31'd0, byte_ready}, 32'd0);
    chk("full_head", outer_inst, 32'hA000_0000);
    @(posedge cpu_clk_50M);
    #1 cpu_ready = 1'b0;
    @(negedge cpu_clk_50M); #1;
    chk("after_pop_ready", {31'd0, byte_ready}, 32'd1);
    chk("after_pop_fill", {28'd0, fill}, 32'd7);
    chk("after_pop_head", outer_inst, 32'hA000_0001);
    @(negedge cpu_clk_50M);
    byte_valid = 1'b0; #1;
    chk("refill_fill", {28'd0, fill}, 32'd8);
    chk("refill_issued", {16'd0, issued}, 32'd1);

    // Streaming with simultaneous push and pop.
    do_reset();
    send_word(32'h1111_0000, 1'b0); sb_q.push_back(32'h1111_0000);
    send_word(32'h1111_0001, 1'b0); sb_q.push_back(32'h1111_0001);
    for (int k = 2; k < 6; k++) begin
      logic [31:0] w;
      w = 32'h1111_0000 + 32'(k);
      send_byte(w[7:0], 1'b0); send_byte(w[15:8], 1'b0); send_byte(w[23:16], 1'b0);
      @(negedge cpu_clk_50M);
      byte_valid = 1'b1; byte_data = w[31:24]; cpu_ready = 1'b1;
      #1;
      chk("stream_ready", {31'd0, byte_ready}, 32'd1);
      chk("stream_head", outer_inst, sb_q.pop_front());
      @(posedge cpu_clk_50M);
      #1 byte_valid = 1'b0; cpu_ready = 1'b0;
      chk("stream_fill_const", {28'd0, fill}, 32'd2);
      sb_q.push_back(w);
    end
    drain();
    @(negedge cpu_clk_50M); #1;
    chk("stream_issued", {16'd0, issued}, 32'd6);
    chk("stream_empty", {28'd0, fill}, 32'd0);

    // Flush mid-word discards buffered words and partial lanes.
    do_reset();
    for (int k = 0; k < 3; k++) send_word(32'hC0DE_0000 + 32'(k), 1'b0);
    send_byte(8'hFF, 1'b0); send_byte(8'hEE, 1'b0);
    @(negedge cpu_clk_50M);
    flush = 1'b1;
    @(posedge cpu_clk_50M);
    #1 flush = 1'b0;
    @(negedge cpu_clk_50M); #1;
    chk("flush_fill", {28'd0, fill}, 32'd0);
    chk("flush_en", {31'd0, en}, 32'd0);
    chk("flush_inst", outer_inst, 32'h0);
    chk("flush_issued", {16'd0, issued}, 32'd0);
    send_word(32'h0403_0201, 1'b0);
    @(negedge cpu_clk_50M); #1;
    chk("flush_fresh_word", outer_inst, 32'h0403_0201);
    chk("flush_fresh_fill", {28'd0, fill}, 32'd1);

    // Issue counter wrap, starting just below the top.
    do_reset();
    @(negedge cpu_clk_50M);
    force dut.issued = 16'hFFFE;
    #1 release dut.issued;
    for (int k = 0; k < 2; k++) begin
      send_word(32'hBEEF_0000 + 32'(k), 1'b0);
      @(negedge cpu_clk_50M);
      cpu_ready = 1'b1;
      @(posedge cpu_clk_50M);
      #1 cpu_ready = 1'b0;
      @(negedge cpu_clk_50M); #1;
      chk($sformatf("wrap_issued%0d", k), {16'd0, issued}, (k == 0) ? 32'h0000_FFFF : 32'h0000_0000);
    end

    // Reset mid-word and mid-stream, with flush and transfers also requested.
    do_reset();
    for (int k = 0; k < 7; k++) send_word(32'h7000_0000 + 32'(k), 1'b1);
    @(negedge cpu_clk_50M);
    cpu_ready = 1'b1;
    @(posedge cpu_clk_50M);
    #1 cpu_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_word(32'h5000_0000 + 32'(k), 1'b0);
    send_byte(8'h99, 1'b0); send_byte(8'h88, 1'b0);
    @(negedge cpu_clk_50M); #1;
    chk("pre_rst_fill", {28'd0, fill}, 32'd5);
    chk("pre_rst_issued", {16'd0, issued}, 32'd7);
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b1; flush = 1'b1; byte_valid = 1'b1; byte_data = 8'h77; cpu_ready = 1'b1;
    @(posedge cpu_clk_50M);
    #1 cpu_rst = 1'b0; flush = 1'b0; byte_valid = 1'b0; cpu_ready = 1'b0;
    @(negedge cpu_clk_50M); #1;
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_inst", outer_inst, 32'h0);
    chk("rst_fill", {28'd0, fill}, 32'd0);
    chk("rst_issued", {16'd0, issued}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd1);
    send_word(32'h89AB_CDEF, 1'b0);
    @(negedge cpu_clk_50M); #1;
    chk("rst_fresh_word", outer_inst, 32'h89AB_CDEF);
    chk("rst_fresh_fill", {28'd0, fill}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_feeder.md
INST_FEEDER -- requirements
Module: inst_feeder

Interface
REQ-001 Parameter DEPTH, default 8, instruction FIFO depth in words; power of two, minimum 2.
REQ-002 cpu_clk_50M  input  1  single clock; all state updates on its rising edge.
REQ-003 cpu_rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discards all buffered and partially assembled instructions.
REQ-005 byte_valid  input  1  loader offers byte_data this cycle.
REQ-006 byte_data  input  8  instruction byte, little-endian order within the word.
REQ-007 byte_ready  output  1  feeder accepts byte_data this cycle.
REQ-008 cpu_ready  input  1  downstream CPU consumes outer_inst this cycle.
REQ-009 en  output  1  outer_inst is valid; drives the CPU en input.
REQ-010 outer_inst  output  32 (inst_t)  instruction presented to the CPU.
REQ-011 fill  output  $clog2(DEPTH)+1  number of buffered complete words.
REQ-012 issued  output  16  count of words handed to the CPU.

Function
REQ-013 A byte transfers when byte_valid and byte_ready are both high; byte_idx (0..3) selects the target lane: bits [8*idx+7 : 8*idx].
REQ-014 On a transfer at byte_idx 3, the assembled word (lanes 0..2 held plus byte_data as lane 3) is written to the FIFO tail in the same edge, and byte_idx wraps to 0.
REQ-015 byte_ready is low when flush is high, or when byte_idx is 3 and fill equals DEPTH; otherwise high (no same-cycle pop bypass).
REQ-016 en is high when fill is nonzero and flush is low.
REQ-017 outer_inst equals the FIFO head word when en is high, and 32'h0000_0000 (NOP) otherwise.
REQ-018 A pop occurs when en and cpu_ready are both high; the head advances and issued increments by 1, wrapping 16'hFFFF to 16'h0000.
REQ-019 A simultaneous push and pop leaves fill unchanged, and both take effect.
REQ-020 The latency from the edge accepting the 4th byte to en high is 1 cycle when the FIFO was empty.
REQ-021 Read and write pointers wrap modulo DEPTH; fill never exceeds DEPTH or drops below 0.
REQ-022 When flush is high: fill goes to 0, pointers go to 0, byte_idx goes to 0, partial lanes are cleared, and issued is held; no push or pop occurs that cycle.
REQ-023 cpu_ready while en is low has no effect.

Reset
REQ-024 When cpu_rst is high at an edge: fill=0, pointers=0, byte_idx=0, lanes=0, issued=0. Consequently en=0, outer_inst=0, and byte_ready=1 from the next cycle.
REQ-025 cpu_rst has priority over flush and all transfers, and takes effect mid-word or mid-stream without residue.
REQ-026 FIFO storage contents need not be reset.

Structure
REQ-027 inst_t and word_t come from mips_cpu_pkg; NOP_INST (32'h0) is added to mips_cpu_pkg.
REQ-028 The FIFO is a sub-module, inst_fifo (storage, pointers, fill), parameterised by DEPTH and using the same clock and reset. Byte assembly and the issue counter live in inst_feeder.

Verification
REQ-029 After reset, send bytes 0x0C,0x00,0x08,0x20 with cpu_ready=0 -> one cycle later en=1, outer_inst=32'h2008000C, fill=1.
REQ-030 Push 8 words with cpu_ready=0, then offer 4 more bytes -> the first 3 are accepted, byte_ready=0 at byte_idx 3, fill=8; pulse cpu_ready for 1 cycle -> the 4th byte is accepted the next cycle and fill stays 8.
REQ-031 Continuous byte stream with cpu_ready=1 -> each word issued exactly once in order, issued counts match, and a simultaneous push/pop keeps fill constant.
REQ-032 Assert flush after 2 bytes of a word with fill=3 -> the next cycle has fill=0, en=0, outer_inst=0, and the next 4 bytes form a fresh word.
REQ-033 Preload issued to 16'hFFFF by issuing 65535 words, then issue 1 -> issued=16'h0000.
REQ-034 Assert cpu_rst mid-word with fill=5 and issued=7 -> all outputs return to the REQ-024 values and the following stream assembles from lane 0.
